// File: rtl/buzzer_pkg.sv
// Shared types for the buzzer arbiter: note codes, C5..B6 pitch table, event patterns
// and the sequencer state encoding.
package buzzer_pkg;

  typedef logic [4:0] note_t;

  localparam note_t NOTE_END  = 5'd30;
  localparam note_t NOTE_REST = 5'd31;

  localparam note_t NOTE_C5 = 5'd0;
  localparam note_t NOTE_A5 = 5'd9;
  localparam note_t NOTE_C6 = 5'd12;
  localparam note_t NOTE_D6 = 5'd14;
  localparam note_t NOTE_E6 = 5'd16;
  localparam note_t NOTE_G6 = 5'd19;
  localparam note_t NOTE_A6 = 5'd21;

  typedef enum logic [2:0] {StIdle, StLoad, StPlay, StGap, StDone} state_e;

  // Half period in 1 MHz clock cycles; codes 0..23 are C5..B6 in semitones.
  function automatic logic [9:0] half_period(input note_t code);
    logic [9:0] hp;
    case (code)
      5'd0:    hp = 10'd956;
      5'd1:    hp = 10'd902;
      5'd2:    hp = 10'd851;
      5'd3:    hp = 10'd804;
      5'd4:    hp = 10'd758;
      5'd5:    hp = 10'd716;
      5'd6:    hp = 10'd676;
      5'd7:    hp = 10'd638;
      5'd8:    hp = 10'd602;
      5'd9:    hp = 10'd568;
      5'd10:   hp = 10'd536;
      5'd11:   hp = 10'd506;
      5'd12:   hp = 10'd478;
      5'd13:   hp = 10'd451;
      5'd14:   hp = 10'd426;
      5'd15:   hp = 10'd402;
      5'd16:   hp = 10'd379;
      5'd17:   hp = 10'd358;
      5'd18:   hp = 10'd338;
      5'd19:   hp = 10'd319;
      5'd20:   hp = 10'd301;
      5'd21:   hp = 10'd284;
      5'd22:   hp = 10'd268;
      5'd23:   hp = 10'd253;
      default: hp = 10'd0;
    endcase
    return hp;
  endfunction

  function automatic note_t pattern_note(input logic [1:0] id, input int unsigned idx);
    note_t n;
    n = NOTE_END;
    case (id)
      2'd0: begin // game over
        case (idx)
          0: n = NOTE_A6;
          1: n = NOTE_E6;
          2: n = NOTE_D6;
          3: n = NOTE_C6;
          4: n = NOTE_A5;
          5: n = NOTE_C6;
          6: n = NOTE_D6;
          7: n = NOTE_E6;
          default: n = NOTE_END;
        endcase
      end
      2'd1: begin // invalid move
        case (idx)
          0: n = NOTE_C5;
          1: n = NOTE_REST;
          2: n = NOTE_C5;
          default: n = NOTE_END;
        endcase
      end
      2'd2: begin // capture
        case (idx)
          0: n = NOTE_C6;
          1: n = NOTE_E6;
          2: n = NOTE_G6;
          default: n = NOTE_END;
        endcase
      end
      default: begin // stone placed
        case (idx)
          0: n = NOTE_C6;
          default: n = NOTE_END;
        endcase
      end
    endcase
    return n;
  endfunction

endpackage

// File: rtl/buzzer_tone_gen.sv
// Square-wave generator: output toggles each time the 10-bit counter reaches half_period.
// load restarts the wave low; mute holds it low and the counter at zero.
module buzzer_tone_gen (
  input  logic       clk,
  input  logic       rst,
  input  logic       load,
  input  logic       mute,
  input  logic [9:0] half_period,
  output logic       wave
);

  logic [9:0] cnt_d, cnt_q;
  logic       wave_d, wave_q;

  always_comb begin
    cnt_d  = cnt_q + 10'd1;
    wave_d = wave_q;
    if (load || mute) begin
      cnt_d  = '0;
      wave_d = 1'b0;
    end else if (cnt_q == half_period) begin
      cnt_d  = '0;
      wave_d = ~wave_q;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q  <= '0;
      wave_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      wave_q <= wave_d;
    end
  end

  assign wave = wave_q;

endmodule

// File: rtl/buzzer_arbiter.sv
// Fixed-priority arbiter sharing one piezo buzzer between sound-event requesters.
// Define BUZZER_PREEMPT_EN to let a higher-priority request abort the playing pattern.
module buzzer_arbiter
  import buzzer_pkg::*;
#(
  parameter int unsigned NUM_REQ     = 4,
  parameter int unsigned STEP_CYCLES = 5000,
  parameter int unsigned NOTE_STEPS  = 25,
  parameter int unsigned GAP_STEPS   = 1,
  parameter int unsigned PAT_LEN     = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               en,
  input  logic [NUM_REQ-1:0] req,
  output logic               busy,
  output logic [1:0]         grant_id,
  output logic               done,
  output logic               buzzer_out
);

  localparam int unsigned PrescW = (STEP_CYCLES > 1) ? $clog2(STEP_CYCLES) : 1;
  localparam int unsigned StepW  = $clog2(NOTE_STEPS + GAP_STEPS + 1);
  localparam int unsigned IdxW   = $clog2(PAT_LEN) + 1;

  state_e             state_d, state_q;
  logic [NUM_REQ-1:0] pending_d, pending_q;
  logic [1:0]         grant_id_d, grant_id_q;
  logic [IdxW-1:0]    note_idx_d, note_idx_q;
  note_t              code_d, code_q;
  logic [9:0]         half_d, half_q;
  logic [PrescW-1:0]  presc_d, presc_q;
  logic [StepW-1:0]   step_d, step_q;
  logic               busy_d, busy_q;
  logic               done_d, done_q;
  logic [1:0]         sel;
  logic               step_tick;
  logic               tone_load;
  logic               mute;
  note_t              cur_code;
`ifdef BUZZER_PREEMPT_EN
  logic               hi_pending;
`endif

  always_comb begin
    state_d    = state_q;
    pending_d  = pending_q;
    grant_id_d = grant_id_q;
    note_idx_d = note_idx_q;
    code_d     = code_q;
    half_d     = half_q;
    presc_d    = '0;
    step_d     = step_q;
    step_tick  = (presc_q == PrescW'(STEP_CYCLES - 1));
    cur_code   = pattern_note(grant_id_q, 32'(note_idx_q));

    sel = '0;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      if (pending_q[i]) sel = 2'(i);
    end
`ifdef BUZZER_PREEMPT_EN
    hi_pending = 1'b0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (pending_q[i] && (2'(i) < grant_id_q)) hi_pending = 1'b1;
    end
`endif

    unique case (state_q)
      StIdle: begin
        if (en && (pending_q != '0)) begin
          grant_id_d     = sel;
          pending_d[sel] = 1'b0;
          note_idx_d     = '0;
          state_d        = StLoad;
        end
      end
      StLoad: begin
        step_d = '0;
        if ((cur_code == NOTE_END) || (note_idx_q == IdxW'(PAT_LEN))) begin
          state_d = StDone;
        end else begin
          code_d  = cur_code;
          half_d  = half_period(cur_code);
          state_d = StPlay;
        end
      end
      StPlay: begin
        presc_d = step_tick ? '0 : presc_q + 1'b1;
        if (step_tick) begin
          if (step_q == StepW'(NOTE_STEPS - 1)) begin
            step_d  = '0;
            state_d = StGap;
          end else begin
            step_d = step_q + 1'b1;
          end
        end
      end
      StGap: begin
        presc_d = step_tick ? '0 : presc_q + 1'b1;
        if (step_tick) begin
          if (step_q == StepW'(GAP_STEPS - 1)) begin
            step_d     = '0;
            note_idx_d = note_idx_q + 1'b1;
            state_d    = StLoad;
          end else begin
            step_d = step_q + 1'b1;
          end
        end
      end
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase

`ifdef BUZZER_PREEMPT_EN
    // Aborted requester is deliberately not re-queued.
    if (((state_q == StPlay) || (state_q == StGap)) && step_tick && hi_pending) begin
      state_d = StIdle;
    end
`endif

    // A request in the grant cycle wins over the clear, re-queueing that requester.
    pending_d = pending_d | req;

    if (!en) begin
      state_d   = StIdle;
      pending_d = '0;
    end

    busy_d    = (state_d != StIdle);
    done_d    = (state_d == StDone);
    tone_load = (state_q == StLoad);
    mute      = (state_d != StPlay) || (code_q == NOTE_REST);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= StIdle;
      pending_q  <= '0;
      grant_id_q <= '0;
      note_idx_q <= '0;
      code_q     <= '0;
      half_q     <= '0;
      presc_q    <= '0;
      step_q     <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      pending_q  <= pending_d;
      grant_id_q <= grant_id_d;
      note_idx_q <= note_idx_d;
      code_q     <= code_d;
      half_q     <= half_d;
      presc_q    <= presc_d;
      step_q     <= step_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
    end
  end

  buzzer_tone_gen u_tone (
    .clk         (clk),
    .rst         (rst),
    .load        (tone_load),
    .mute        (mute),
    .half_period (half_q),
    .wave        (buzzer_out)
  );

  assign busy     = busy_q;
  assign grant_id = grant_id_q;
  assign done     = done_q;

endmodule

// File: tb/tb_buzzer_arbiter.sv
// Directed bench for buzzer_arbiter: a short-timing instance for arbitration/sequencing and a
// long-timing instance where tone periods fit inside a note.
module tb_buzzer_arbiter;

  localparam int StepC   = 10;
  localparam int NoteS   = 2;
  localparam int GapS    = 1;
  localparam int NoteCyc = 1 + (NoteS + GapS) * StepC;
  localparam int LStepC  = 100;
  localparam int LNoteS  = 10;
  localparam int LNoteCyc = 1 + (LNoteS + GapS) * LStepC;

  typedef struct {
    logic [1:0] id;
    int         at;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst, en;
  logic [3:0] req, req_l;
  logic       busy, done, buzz;
  logic [1:0] gid;
  logic       busy_l, done_l, buzz_l;
  logic [1:0] gid_l;

  int   checks = 0;
  int   failures = 0;
  int   cyc = 0;
  int   done_cnt = 0;
  int   busy_cnt = 0;
  int   buzz_cnt = 0;
  exp_t exp_q[$];

  always #5 clk = ~clk;

  buzzer_arbiter #(
    .NUM_REQ(4), .STEP_CYCLES(StepC), .NOTE_STEPS(NoteS), .GAP_STEPS(GapS), .PAT_LEN(8)
  ) dut (
    .clk(clk), .rst(rst), .en(en), .req(req),
    .busy(busy), .grant_id(gid), .done(done), .buzzer_out(buzz)
  );

  buzzer_arbiter #(
    .NUM_REQ(4), .STEP_CYCLES(LStepC), .NOTE_STEPS(LNoteS), .GAP_STEPS(GapS), .PAT_LEN(8)
  ) dut_l (
    .clk(clk), .rst(rst), .en(en), .req(req_l),
    .busy(busy_l), .grant_id(gid_l), .done(done_l), .buzzer_out(buzz_l)
  );

  always @(negedge clk) begin
    if (done === 1'b1) done_cnt++;
    if (busy === 1'b1) busy_cnt++;
    if (buzz === 1'b1) buzz_cnt++;
  end

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic wait_until(input int t);
    while (cyc < t) tick();
  endtask

  task automatic pulse(input logic [3:0] v);
    req = v;
    tick();
    req = '0;
  endtask

  task automatic pulse_l(input logic [3:0] v);
    req_l = v;
    tick();
    req_l = '0;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Wait (bounded) for done, then pop the scoreboard and compare id and cycle.
  task automatic expect_done(input string tag, input int bound);
    int   n;
    exp_t e;
    n = 0;
    while (done !== 1'b1 && n < bound) begin
      tick();
      n++;
    end
    check({tag, "_done_seen"}, 32'(done), 32'd1);
    check({tag, "_sb_nonempty"}, 32'(exp_q.size() > 0), 32'd1);
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      check({tag, "_grant_id"}, 32'(gid), 32'(e.id));
      check({tag, "_done_cycle"}, cyc, e.at);
    end
    tick();
  endtask

  function automatic int done_at(input int s, input int notes, input int ncyc);
    return s + 2 + notes * ncyc;
  endfunction

  initial begin
    int s, d0, b0;
    rst = 1'b1; en = 1'b1; req = '0; req_l = '0;
    tick(); tick();
    check("rst_busy", 32'(busy), 0);
    check("rst_grant", 32'(gid), 0);
    check("rst_done", 32'(done), 0);
    check("rst_buzz", 32'(buzz), 0);
    rst = 1'b0;
    tick();

    // Single stone-placed pattern
    b0 = buzz_cnt;
    pulse(4'b1000); s = cyc;
    check("pend_not_busy", 32'(busy), 0);
    exp_q.push_back('{2'd3, done_at(s, 1, NoteCyc)});
    tick();
    check("grant_busy", 32'(busy), 1);
    check("grant_id3", 32'(gid), 3);
    expect_done("id3", 100);
    check("busy_after_done", 32'(busy), 0);
    check("c6_no_toggle_short", buzz_cnt - b0, 0);

    // Priority and queuing
    d0 = done_cnt;
    pulse(4'b1010); s = cyc;
    exp_q.push_back('{2'd1, done_at(s, 3, NoteCyc)});
    exp_q.push_back('{2'd3, done_at(done_at(s, 3, NoteCyc) + 1, 1, NoteCyc)});
    expect_done("prio_id1", 200);
    expect_done("prio_id3", 100);
    repeat (40) tick();
    check("prio_two_dones", done_cnt - d0, 2);
    check("prio_idle", 32'(busy), 0);

    // Retrigger in grant cycle
    d0 = done_cnt;
    pulse(4'b0100); s = cyc;
    pulse(4'b0100);
    exp_q.push_back('{2'd2, done_at(s, 3, NoteCyc)});
    exp_q.push_back('{2'd2, done_at(done_at(s, 3, NoteCyc) + 1, 3, NoteCyc)});
    expect_done("retrig_a", 200);
    expect_done("retrig_b", 200);
    repeat (20) tick();
    check("retrig_two_dones", done_cnt - d0, 2);

    // Mute during id0's third note
    d0 = done_cnt;
    pulse(4'b0001); s = cyc;
    wait_until(s + 2 + 2 * NoteCyc + 6);
    check("mute_pre_busy", 32'(busy), 1);
    en = 1'b0;
    tick();
    check("mute_busy", 32'(busy), 0);
    check("mute_buzz", 32'(buzz), 0);
    check("mute_done", 32'(done), 0);
    pulse(4'b0001);
    tick(); tick();
    en = 1'b1;
    b0 = busy_cnt;
    repeat (40) tick();
    check("mute_req_ignored", busy_cnt - b0, 0);
    check("mute_no_done", done_cnt - d0, 0);

    // Synchronous reset mid-PLAY with a request pending
    d0 = done_cnt;
    pulse(4'b1000); s = cyc;
    wait_until(s + 5);
    pulse(4'b0010);
    wait_until(s + 8);
    check("rstmid_pre_grant", 32'(gid), 3);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("rstmid_busy", 32'(busy), 0);
    check("rstmid_grant", 32'(gid), 0);
    check("rstmid_done", 32'(done), 0);
    check("rstmid_buzz", 32'(buzz), 0);
    b0 = busy_cnt;
    repeat (40) tick();
    check("rstmid_pending_cleared", busy_cnt - b0, 0);
    check("rstmid_no_done", done_cnt - d0, 0);

    // Higher-priority request while id3 plays
    pulse(4'b1000); s = cyc;
    wait_until(s + 5);
    pulse(4'b0001);
`ifdef BUZZER_PREEMPT_EN
    exp_q.push_back('{2'd0, done_at(s + StepC + 2, 8, NoteCyc)});
    wait_until(s + StepC + 2);
    check("preempt_abort_busy", 32'(busy), 0);
    expect_done("preempt_id0", 400);
`else
    exp_q.push_back('{2'd3, done_at(s, 1, NoteCyc)});
    exp_q.push_back('{2'd0, done_at(done_at(s, 1, NoteCyc) + 1, 8, NoteCyc)});
    expect_done("wait_id3", 100);
    expect_done("wait_id0", 400);
`endif

    // Tone timing on the long instance: C6 toggles every 479 cycles
    pulse_l(4'b1000); s = cyc;
    wait_until(s + 2 + 478);
    check("c6_pre_toggle", 32'(buzz_l), 0);
    check("c6_grant_l", 32'(gid_l), 3);
    tick();
    check("c6_toggle1", 32'(buzz_l), 1);
    wait_until(s + 2 + 957);
    check("c6_pre_toggle2", 32'(buzz_l), 1);
    tick();
    check("c6_toggle2", 32'(buzz_l), 0);
    while (done_l !== 1'b1 && cyc < s + 1300) tick();
    check("long_id3_done_cycle", cyc, done_at(s, 1, LNoteCyc));
    tick();
    check("long_idle", 32'(busy_l), 0);

    // C5 (half 956) then a silent REST note
    pulse_l(4'b0010); s = cyc;
    wait_until(s + 2 + 956);
    check("c5_pre_toggle", 32'(buzz_l), 0);
    tick();
    check("c5_toggle", 32'(buzz_l), 1);
    wait_until(s + 1500);
    check("rest_silent_a", 32'(buzz_l), 0);
    tick();
    check("rest_silent_b", 32'(buzz_l), 0);
    while (done_l !== 1'b1 && cyc < s + 3500) tick();
    check("long_id1_done_cycle", cyc, done_at(s, 3, LNoteCyc));

    check("sb_drained", exp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
